// File: rtl/w_tx_pkg.sv
// Shared types and helpers for the w-interface pattern transmitter.
package w_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    function automatic int cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/w_z_model.sv
// Predicts the one-hot detector's z: high when the last two sampled w values match.
module w_z_model (
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic z_exp
);

    logic z_q;
    logic w_prev_q;
    logic seen_q;

    // seen_q keeps z low on the first edge after reset, when w_prev_q is not real history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_q      <= 1'b0;
            w_prev_q <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            z_q      <= seen_q & (w == w_prev_q);
            w_prev_q <= w;
            seen_q   <= 1'b1;
        end
    end

    assign z_exp = z_q;

endmodule

// File: rtl/w_pattern_tx.sv
// Serial w-stream transmitter: shifts a captured pattern out LSB first and
// predicts the downstream detector's z output.
module w_pattern_tx
    import w_tx_pkg::*;
#(
    parameter  int MAX_LEN = 16,
    localparam int CNT_W   = cnt_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   length,
    output logic               ready,
    output logic               w,
    output logic               w_valid,
    output logic               done,
    output logic               z_exp
);

    tx_state_t          state_q, state_d;
    logic [MAX_LEN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   len_clamped;

    assign len_clamped = (length > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : length;

    // w is taken straight from bit 0 of the shift register; the register only
    // moves in SEND, so w holds the last bit sent while idle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEND;
                        shreg_d = pattern;
                        cnt_d   = len_clamped;
                    end
                end
            end
            SEND: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign w_valid = (state_q == SEND);
    assign w       = shreg_q[0];
    assign done    = done_q;

    w_z_model u_z_model (
        .clk   (clk),
        .reset (reset),
        .w     (w),
        .z_exp (z_exp)
    );

endmodule

// File: tb/tb_w_pattern_tx.sv
// Directed plus randomized frames checked against a stream-level model of the w interface.
module tb_w_pattern_tx;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [CNT_W-1:0]   length;
    logic               ready, w, w_valid, done, z_exp;

    int total = 0;
    int bad   = 0;

    // Model: expected current w level and the w values the detector sampled since reset.
    logic m_w;
    logic hist[$];

    always #5 clk = ~clk;

    w_pattern_tx #(.MAX_LEN(MAX_LEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .length  (length),
        .ready   (ready),
        .w       (w),
        .w_valid (w_valid),
        .done    (done),
        .z_exp   (z_exp)
    );

    function automatic logic zexp();
        if (hist.size() < 2) return 1'b0;
        return hist[$] == hist[$-1];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rdy, input logic wv, input logic dn);
        chk({tag, ".ready"},   ready,   rdy);
        chk({tag, ".w_valid"}, w_valid, wv);
        chk({tag, ".done"},    done,    dn);
        chk({tag, ".w"},       w,       m_w);
        chk({tag, ".z_exp"},   z_exp,   zexp());
    endtask

    // One clock edge; nw is the w level expected after it.
    task automatic step(input logic nw);
        @(posedge clk);
        if (reset) hist.push_back(m_w);
        m_w = nw;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check_out("idle", 1'b1, 1'b0, 1'b0);
            step(m_w);
        end
    endtask

    task automatic frame(input logic [MAX_LEN-1:0] pat, input int len, input bit poke);
        int lc;
        lc      = (len > MAX_LEN) ? MAX_LEN : len;
        pattern = pat;
        length  = CNT_W'(len);
        start   = 1'b1;
        step((lc != 0) ? pat[0] : m_w);
        start   = 1'b0;
        pattern = MAX_LEN'($urandom);
        length  = CNT_W'($urandom);
        if (lc == 0) begin
            check_out("zlen_done", 1'b1, 1'b0, 1'b1);
            step(m_w);
            check_out("zlen_after", 1'b1, 1'b0, 1'b0);
            return;
        end
        for (int k = 0; k < lc; k++) begin
            check_out("bit", 1'b0, 1'b1, 1'b0);
            pattern = MAX_LEN'($urandom);
            start   = poke && (k == 1 || k == lc - 1);
            if (start) begin
                pattern = '0;
                length  = CNT_W'(4);
            end
            step((k + 1 < lc) ? pat[k+1] : m_w);
        end
        start = 1'b0;
        check_out("done", 1'b0, 1'b0, 1'b1);
        step(m_w);
        check_out("ready_back", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [MAX_LEN-1:0] pat;
        reset   = 1'b0;
        start   = 1'b0;
        pattern = '0;
        length  = '0;
        m_w     = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_out("in_reset", 1'b1, 1'b0, 1'b0);
            step(1'b0);
        end
        reset = 1'b1;
        check_out("post_reset", 1'b1, 1'b0, 1'b0);

        idle(2);
        frame(16'h0033, 8, 1'b0);
        idle(1);
        frame(16'h1234, 0, 1'b0);
        idle(1);
        frame(16'hFFFF, 20, 1'b0);
        idle(2);
        frame(16'hA5C3, 9, 1'b1);
        idle(1);

        // reset during the 4th bit of a 10-bit frame
        pat     = 16'h02D6;
        pattern = pat;
        length  = CNT_W'(10);
        start   = 1'b1;
        step(pat[0]);
        start   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_out("pre_rst_bit", 1'b0, 1'b1, 1'b0);
            step(pat[k+1]);
        end
        check_out("bit4", 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        hist.delete();
        m_w = 1'b0;
        check_out("mid_reset", 1'b1, 1'b0, 1'b0);
        step(1'b0);
        check_out("mid_reset_hold", 1'b1, 1'b0, 1'b0);
        step(1'b0);
        reset = 1'b1;
        idle(3);
        frame(16'h0005, 3, 1'b0);
        idle(1);

        for (int r = 0; r < 12; r++) begin
            frame(MAX_LEN'($urandom), $urandom_range(0, 20), bit'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/w_pattern_tx.md
Name: w_pattern_tx

Overview:
- Transmitter side of the serial `w` interface that our one-hot sequence detector consumes.
- Loads a bit pattern and a length, then shifts the pattern out on `w`, LSB first, one bit per clock.
- Also produces `z_exp`, a cycle-accurate prediction of the detector's `z` output, so a bench can check the detector directly against this block.
- Sits upstream of the detector in lab test harnesses and in the board top-level.

Parameters:
- MAX_LEN, 16, width of the `pattern` port and the longest frame length accepted.
- CNT_W, $clog2(MAX_LEN+1), width of the `length` port and of the internal bit counter. Derived; never overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Reset is asserted when `reset`=0.
- start  in  1  frame request; sampled only when `ready`=1.
- pattern  in  MAX_LEN  bits to send; bit 0 is sent first.
- length  in  CNT_W  number of bits to send.
- ready  out  1  block is idle and will accept `start`.
- w  out  1  serial data to the detector; registered output.
- w_valid  out  1  `w` carries a frame bit this cycle.
- done  out  1  one-cycle pulse marking the end of a frame.
- z_exp  out  1  predicted detector `z`; registered output.

Behaviour:
- Reset values, applied asynchronously while `reset`=0:
  - state=IDLE, `ready`=1, `w`=0, `w_valid`=0, `done`=0, `z_exp`=0.
  - Shift register, counter, `w_prev` and `seen` all cleared to 0.
- States: IDLE, SEND, DONE. State is binary-encoded.
- IDLE:
  - `ready`=1.
  - On an edge with `start`=1 and `length`!=0: capture `pattern` and Lc = min(`length`, MAX_LEN), then go to SEND.
  - On an edge with `start`=1 and `length`=0: stay in IDLE and pulse `done` for one cycle. `w_valid` stays 0.
- SEND:
  - `ready`=0 and `w_valid`=1.
  - `w` = the current bit. Bit 0 appears in the first cycle after the accepting edge.
  - Each edge shifts the register right by one and decrements the counter.
  - After Lc cycles, go to DONE.
- DONE:
  - Lasts exactly one cycle, with `done`=1, `ready`=0, `w_valid`=0.
  - Then return to IDLE.
- Latency:
  - `start` is accepted at edge T0.
  - `w_valid` is high for cycles T0+1 through T0+Lc.
  - `done` is high in cycle T0+Lc+1.
  - `ready` returns to 1 in cycle T0+Lc+2.
- Idle level of `w`: outside SEND, `w` holds the last bit sent (0 after reset). The detector samples every cycle, so this level is part of the stream.
- `start` while `ready`=0 is ignored and not queued.
- `pattern` and `length` changes after the accepting edge have no effect on the current frame.
- z_exp model (detector semantics):
  - Updated on every edge while out of reset, regardless of state.
  - `z_exp` <= `seen` & (`w` == `w_prev`).
  - `w_prev` <= `w`.
  - `seen` <= 1.
  - Net effect: `z_exp`=1 exactly when the last two values sampled by the detector are equal, and it stays 0 on the first edge after reset.
  - History is not cleared between frames.
- Reset mid-frame: the frame is abandoned, all outputs take their reset values immediately, and no `done` is produced.

Decomposition:
- Package w_tx_pkg holds:
  - the state enum `tx_state_t` {IDLE, SEND, DONE};
  - the function `cnt_w(max_len)` used to derive CNT_W.
- Sub-module w_z_model holds `w_prev`, `seen` and the `z_exp` register.
  - Ports: clk, reset, w, z_exp.
  - Reusable as a stand-alone scoreboard model for detector benches.

Test Plan:
- Reset: hold `reset`=0 for 3 cycles, then release -> `ready`=1, `w`=0, `w_valid`=0, `done`=0, `z_exp`=0, including during reset.
- Basic frame: after 2 idle cycles, `pattern`=16'h0033, `length`=8, pulse `start` ->
  - `w`=1,1,0,0,1,1,0,0 with `w_valid`=1 for 8 cycles;
  - `done`=1 in cycle 9;
  - `z_exp` after each bit edge = 0,1,0,1,0,1,0,1;
  - `ready`=1 in cycle 10.
- Zero length: `length`=0 with `start` -> `done` pulses for exactly 1 cycle, `w_valid` never rises, `ready` stays 1.
- Clamp: `length`=20 (CNT_W=5), `pattern`=16'hFFFF -> exactly 16 `w_valid` cycles of `w`=1, then `done`; `z_exp`=1 from the second bit on.
- Busy: during SEND, pulse `start` with `pattern`=0 and `length`=4, and change the `pattern` port -> no effect on the frame in flight, no second frame, exactly one `done`.
- Reset mid-frame: drop `reset` during the 4th bit of a 10-bit frame -> immediate reset values and no `done`; after release, a new `pattern`=16'h0005, `length`=3 frame sends 1,0,1 correctly.
